// File: rtl/pcie_s10_tx_fc_tracker.sv
// TX flow-control credit tracker for the Stratix 10 PCIe hard IP.
// Grants TLP requests against the P/NP/CPL header and data credits that remain after consumed and reserved credits.

module pcie_s10_tx_fc_chan #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          first_i,
    input  logic [W-1:0]  limit_i,
    input  logic [CW-1:0] cons_i,
    input  logic [W-1:0]  grant_i,
    output logic [W-1:0]  av_o,
    output logic          inf_o,
    output logic          uflow_o
);
    logic [W-1:0]  l_q, c_q, r_q;
    logic [W-1:0]  c_d, r_d, a_raw, grant_eff, cons_w;
    logic [W:0]    r_plus, cons_ext;
    logic          inf_q;

    always_comb begin
        a_raw     = l_q - c_q - r_q;
        av_o      = inf_q ? '1 : (a_raw[W-1] ? '0 : a_raw);
        inf_o     = inf_q;
        // An infinite channel never reserves, so its consumption must not count as underflow.
        grant_eff = inf_q ? '0 : grant_i;
        cons_w    = inf_q ? '0 : {{(W-CW){1'b0}}, cons_i};
        r_plus    = {1'b0, r_q} + {1'b0, grant_eff};
        cons_ext  = {1'b0, cons_w};
        uflow_o   = cons_ext > r_plus;
        c_d       = c_q + {{(W-CW){1'b0}}, cons_i};
        r_d       = uflow_o ? '0 : (r_q + grant_eff - cons_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q   <= '0;
            c_q   <= '0;
            r_q   <= '0;
            inf_q <= 1'b0;
        end else begin
            l_q <= limit_i;
            c_q <= c_d;
            r_q <= r_d;
            if (first_i) begin
                inf_q <= (limit_i == '0);
            end
        end
    end
endmodule

module pcie_s10_tx_fc_tracker #(
    parameter int SEG_COUNT  = 1,
    parameter int HDR_WIDTH  = 8,
    parameter int DATA_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HDR_WIDTH-1:0]   tx_ph_cdts,
    input  logic [HDR_WIDTH-1:0]   tx_nph_cdts,
    input  logic [HDR_WIDTH-1:0]   tx_cplh_cdts,
    input  logic [DATA_WIDTH-1:0]  tx_pd_cdts,
    input  logic [DATA_WIDTH-1:0]  tx_npd_cdts,
    input  logic [DATA_WIDTH-1:0]  tx_cpld_cdts,
    input  logic [SEG_COUNT-1:0]   tx_hdr_cdts_consumed,
    input  logic [SEG_COUNT-1:0]   tx_data_cdts_consumed,
    input  logic [SEG_COUNT*2-1:0] tx_cdts_type,
    input  logic [SEG_COUNT-1:0]   tx_cdts_data_value,
    input  logic                   req_valid,
    input  logic [1:0]             req_type,
    input  logic [DATA_WIDTH-1:0]  req_data_cdts,
    output logic                   req_ready,
    output logic [HDR_WIDTH-1:0]   ph_av,
    output logic [HDR_WIDTH-1:0]   nph_av,
    output logic [HDR_WIDTH-1:0]   cplh_av,
    output logic [DATA_WIDTH-1:0]  pd_av,
    output logic [DATA_WIDTH-1:0]  npd_av,
    output logic [DATA_WIDTH-1:0]  cpld_av,
    output logic [5:0]             infinite,
    output logic                   underflow_err
);
    localparam int CW = 4;

    logic                  first_q, uf_q, uf_d;
    logic [CW-1:0]         ph_cons, nph_cons, cplh_cons, pd_cons, npd_cons, cpld_cons, dv;
    logic [HDR_WIDTH-1:0]  h_av, ph_g, nph_g, cplh_g;
    logic [DATA_WIDTH-1:0] d_av, pd_g, npd_g, cpld_g;
    logic                  h_inf, d_inf, type_ok;
    logic [5:0]            uflow;

    always_comb begin
        ph_cons = '0; nph_cons = '0; cplh_cons = '0;
        pd_cons = '0; npd_cons = '0; cpld_cons = '0;
        dv      = '0;
        for (int s = 0; s < SEG_COUNT; s++) begin
            dv = tx_cdts_data_value[s] ? CW'(2) : CW'(1);
            if (tx_hdr_cdts_consumed[s]) begin
                case (tx_cdts_type[2*s +: 2])
                    2'd0:    ph_cons   = ph_cons + CW'(1);
                    2'd1:    nph_cons  = nph_cons + CW'(1);
                    2'd2:    cplh_cons = cplh_cons + CW'(1);
                    default: ;
                endcase
            end
            if (tx_data_cdts_consumed[s]) begin
                case (tx_cdts_type[2*s +: 2])
                    2'd0:    pd_cons   = pd_cons + dv;
                    2'd1:    npd_cons  = npd_cons + dv;
                    2'd2:    cpld_cons = cpld_cons + dv;
                    default: ;
                endcase
            end
        end
    end

    // Grant decision sees only registered credit state plus the request itself.
    always_comb begin
        h_av    = '0;
        d_av    = '0;
        h_inf   = 1'b0;
        d_inf   = 1'b0;
        type_ok = 1'b1;
        case (req_type)
            2'd0:    begin h_av = ph_av;   d_av = pd_av;   h_inf = infinite[0]; d_inf = infinite[1]; end
            2'd1:    begin h_av = nph_av;  d_av = npd_av;  h_inf = infinite[2]; d_inf = infinite[3]; end
            2'd2:    begin h_av = cplh_av; d_av = cpld_av; h_inf = infinite[4]; d_inf = infinite[5]; end
            default: type_ok = 1'b0;
        endcase
        req_ready = req_valid && !rst && type_ok
                    && (h_inf || (h_av != '0))
                    && (d_inf || (req_data_cdts == '0) || (d_av >= req_data_cdts));
        ph_g   = (req_ready && req_type == 2'd0) ? HDR_WIDTH'(1) : '0;
        nph_g  = (req_ready && req_type == 2'd1) ? HDR_WIDTH'(1) : '0;
        cplh_g = (req_ready && req_type == 2'd2) ? HDR_WIDTH'(1) : '0;
        pd_g   = (req_ready && req_type == 2'd0) ? req_data_cdts : '0;
        npd_g  = (req_ready && req_type == 2'd1) ? req_data_cdts : '0;
        cpld_g = (req_ready && req_type == 2'd2) ? req_data_cdts : '0;
        uf_d   = uf_q | (|uflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
            uf_q    <= 1'b0;
        end else begin
            first_q <= 1'b0;
            uf_q    <= uf_d;
        end
    end

    assign underflow_err = uf_q;

    pcie_s10_tx_fc_chan #(.W(HDR_WIDTH), .CW(CW)) u_ph (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_ph_cdts), .cons_i(ph_cons),
        .grant_i(ph_g), .av_o(ph_av), .inf_o(infinite[0]), .uflow_o(uflow[0]));
    pcie_s10_tx_fc_chan #(.W(DATA_WIDTH), .CW(CW)) u_pd (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_pd_cdts), .cons_i(pd_cons),
        .grant_i(pd_g), .av_o(pd_av), .inf_o(infinite[1]), .uflow_o(uflow[1]));
    pcie_s10_tx_fc_chan #(.W(HDR_WIDTH), .CW(CW)) u_nph (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_nph_cdts), .cons_i(nph_cons),
        .grant_i(nph_g), .av_o(nph_av), .inf_o(infinite[2]), .uflow_o(uflow[2]));
    pcie_s10_tx_fc_chan #(.W(DATA_WIDTH), .CW(CW)) u_npd (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_npd_cdts), .cons_i(npd_cons),
        .grant_i(npd_g), .av_o(npd_av), .inf_o(infinite[3]), .uflow_o(uflow[3]));
    pcie_s10_tx_fc_chan #(.W(HDR_WIDTH), .CW(CW)) u_cplh (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_cplh_cdts), .cons_i(cplh_cons),
        .grant_i(cplh_g), .av_o(cplh_av), .inf_o(infinite[4]), .uflow_o(uflow[4]));
    pcie_s10_tx_fc_chan #(.W(DATA_WIDTH), .CW(CW)) u_cpld (
        .clk(clk), .rst(rst), .first_i(first_q), .limit_i(tx_cpld_cdts), .cons_i(cpld_cons),
        .grant_i(cpld_g), .av_o(cpld_av), .inf_o(infinite[5]), .uflow_o(uflow[5]));
endmodule

// File: tb/tb_pcie_s10_tx_fc_tracker.sv
// Directed bench for pcie_s10_tx_fc_tracker with two consume segments.
// A vector table covers grant/hold behaviour; hand-written sequences cover consume, underflow, wrap and reset.

module tb_pcie_s10_tx_fc_tracker;
    localparam int SEG = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_ph_cdts = '0, tx_nph_cdts = '0, tx_cplh_cdts = '0;
    logic [11:0] tx_pd_cdts = '0, tx_npd_cdts = '0, tx_cpld_cdts = '0;
    logic [SEG-1:0]   hdr_cons = '0, data_cons = '0, data_val = '0;
    logic [SEG*2-1:0] cdts_type = '0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_type = '0;
    logic [11:0] req_data = '0;
    logic        req_ready;
    logic [7:0]  ph_av, nph_av, cplh_av;
    logic [11:0] pd_av, npd_av, cpld_av;
    logic [5:0]  infinite;
    logic        underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    pcie_s10_tx_fc_tracker #(.SEG_COUNT(SEG), .HDR_WIDTH(8), .DATA_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .tx_ph_cdts(tx_ph_cdts), .tx_nph_cdts(tx_nph_cdts), .tx_cplh_cdts(tx_cplh_cdts),
        .tx_pd_cdts(tx_pd_cdts), .tx_npd_cdts(tx_npd_cdts), .tx_cpld_cdts(tx_cpld_cdts),
        .tx_hdr_cdts_consumed(hdr_cons), .tx_data_cdts_consumed(data_cons),
        .tx_cdts_type(cdts_type), .tx_cdts_data_value(data_val),
        .req_valid(req_valid), .req_type(req_type), .req_data_cdts(req_data),
        .req_ready(req_ready),
        .ph_av(ph_av), .nph_av(nph_av), .cplh_av(cplh_av),
        .pd_av(pd_av), .npd_av(npd_av), .cpld_av(cpld_av),
        .infinite(infinite), .underflow_err(underflow_err));

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  typ;
        logic [11:0] data;
        logic        rdy;
        logic [7:0]  ph;
        logic [11:0] pd;
        logic [7:0]  nph;
        logic [11:0] npd;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_vec(input int i, input int v, input int t, input int d, input int r,
                           input int ph, input int pd, input int nph, input int npd);
        tbl[i].vld  = v[0];
        tbl[i].typ  = t[1:0];
        tbl[i].data = d[11:0];
        tbl[i].rdy  = r[0];
        tbl[i].ph   = ph[7:0];
        tbl[i].pd   = pd[11:0];
        tbl[i].nph  = nph[7:0];
        tbl[i].npd  = npd[11:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        hdr_cons = '0; data_cons = '0; data_val = '0; cdts_type = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        set_vec(0,  1, 0, 4,  1, 4, 16, 10, 40);
        set_vec(1,  1, 0, 4,  1, 3, 12, 10, 40);
        set_vec(2,  1, 0, 4,  1, 2, 8,  10, 40);
        set_vec(3,  1, 0, 4,  1, 1, 4,  10, 40);
        set_vec(4,  1, 0, 4,  0, 0, 0,  10, 40);
        set_vec(5,  1, 1, 8,  1, 0, 0,  10, 40);
        set_vec(6,  1, 1, 40, 0, 0, 0,  9,  32);
        set_vec(7,  1, 1, 32, 1, 0, 0,  9,  32);
        set_vec(8,  1, 1, 0,  1, 0, 0,  8,  0);
        set_vec(9,  1, 1, 1,  0, 0, 0,  7,  0);
        set_vec(10, 1, 3, 0,  0, 0, 0,  7,  0);
        set_vec(11, 0, 0, 0,  0, 0, 0,  7,  0);

        // Reset state, with a request pending and limits applied.
        tx_ph_cdts = 8'd4;  tx_pd_cdts = 12'd16;
        tx_nph_cdts = 8'd10; tx_npd_cdts = 12'd40;
        tx_cplh_cdts = 8'd0; tx_cpld_cdts = 12'd0;
        rst = 1'b1;
        req_valid = 1'b1; req_type = 2'd0; req_data = 12'd1;
        tick();
        settle();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_ph_av", 32'(ph_av), 32'd0);
        check("rst_pd_av", 32'(pd_av), 32'd0);
        check("rst_cpld_av", 32'(cpld_av), 32'd0);
        check("rst_infinite", 32'(infinite), 32'd0);
        check("rst_underflow", 32'(underflow_err), 32'd0);

        do_reset();
        check("inf_flags", 32'(infinite), 32'h30);

        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].vld; req_type = tbl[i].typ; req_data = tbl[i].data;
            settle();
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_ph_av", i), 32'(ph_av), 32'(tbl[i].ph));
            check($sformatf("vec%0d_pd_av", i), 32'(pd_av), 32'(tbl[i].pd));
            check($sformatf("vec%0d_nph_av", i), 32'(nph_av), 32'(tbl[i].nph));
            check($sformatf("vec%0d_npd_av", i), 32'(npd_av), 32'(tbl[i].npd));
            tick();
        end

        // Infinite completion credits: every request granted, no reservation.
        for (int i = 0; i < 100; i++) begin
            req_valid = 1'b1; req_type = 2'd2; req_data = 12'd32;
            settle();
            check("cpl_inf_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        settle();
        check("cplh_av_ones", 32'(cplh_av), 32'hff);
        check("cpld_av_ones", 32'(cpld_av), 32'hfff);

        // Two-segment consume after two grants of 2 data credits.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_type = 2'd0; req_data = 12'd2;
            settle();
            check("seg_grant", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        check("seg_r_ph_pre", 32'(dut.u_ph.r_q), 32'd2);
        check("seg_r_pd_pre", 32'(dut.u_pd.r_q), 32'd4);
        hdr_cons = 2'b11; data_cons = 2'b11; data_val = 2'b11; cdts_type = 4'b0000;
        tick();
        hdr_cons = '0; data_cons = '0; data_val = '0;
        settle();
        check("seg_r_ph", 32'(dut.u_ph.r_q), 32'd0);
        check("seg_r_pd", 32'(dut.u_pd.r_q), 32'd0);
        check("seg_c_ph", 32'(dut.u_ph.c_q), 32'd2);
        check("seg_c_pd", 32'(dut.u_pd.c_q), 32'd4);
        check("seg_ph_av", 32'(ph_av), 32'd2);
        check("seg_pd_av", 32'(pd_av), 32'd12);
        check("seg_no_uflow", 32'(underflow_err), 32'd0);

        // NP header consumed with nothing reserved; segment 1 type 3 is ignored.
        hdr_cons = 2'b11; cdts_type = 4'b1101;
        tick();
        hdr_cons = '0; cdts_type = '0;
        settle();
        check("uf_set", 32'(underflow_err), 32'd1);
        check("uf_r_nph", 32'(dut.u_nph.r_q), 32'd0);
        check("uf_c_nph", 32'(dut.u_nph.c_q), 32'd1);
        check("uf_c_ph_ignored", 32'(dut.u_ph.c_q), 32'd2);
        check("uf_nph_av", 32'(nph_av), 32'd9);
        tick(); tick(); tick();
        check("uf_sticky", 32'(underflow_err), 32'd1);

        // Reset with PD reservation outstanding; CPL limits now nonzero.
        tx_pd_cdts = 12'd40;
        tick();
        settle();
        check("pre_rst_pd_av", 32'(pd_av), 32'd36);
        req_valid = 1'b1; req_type = 2'd0; req_data = 12'd20;
        settle();
        check("pre_rst_grant", 32'(req_ready), 32'd1);
        tick();
        check("pre_rst_r_pd", 32'(dut.u_pd.r_q), 32'd20);
        tx_cplh_cdts = 8'd5; tx_cpld_cdts = 12'd50;
        req_data = 12'd1;
        rst = 1'b1;
        settle();
        check("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        check("midrst_r_pd", 32'(dut.u_pd.r_q), 32'd0);
        check("midrst_c_pd", 32'(dut.u_pd.c_q), 32'd0);
        check("midrst_c_ph", 32'(dut.u_ph.c_q), 32'd0);
        check("midrst_uflow", 32'(underflow_err), 32'd0);
        check("midrst_pd_av", 32'(pd_av), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("postrst_infinite", 32'(infinite), 32'd0);
        check("postrst_pd_av", 32'(pd_av), 32'd40);
        check("postrst_cplh_av", 32'(cplh_av), 32'd5);

        // Drive C_ph to 250 with grant and consume in the same cycle, then wrap the limit.
        tx_ph_cdts = 8'd50;
        do_reset();
        for (int i = 0; i < 250; i++) begin
            tx_ph_cdts = 8'(i + 50);
            req_valid = 1'b1; req_type = 2'd0; req_data = 12'd0;
            hdr_cons = 2'b01; cdts_type = 4'b0000;
            settle();
            check("wrap_fill_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0; hdr_cons = '0;
        check("wrap_c_ph", 32'(dut.u_ph.c_q), 32'd250);
        check("wrap_r_ph", 32'(dut.u_ph.r_q), 32'd0);
        check("wrap_no_uflow", 32'(underflow_err), 32'd0);
        tx_ph_cdts = 8'd254;
        tick();
        check("wrap_ph_av_254", 32'(ph_av), 32'd4);
        tx_ph_cdts = 8'd2;
        tick();
        check("wrap_ph_av_2", 32'(ph_av), 32'd8);
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1; req_type = 2'd0; req_data = 12'd0;
            settle();
            check($sformatf("wrap_grant%0d", i), 32'(req_ready), (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        req_valid = 1'b0;
        settle();
        check("wrap_ph_av_end", 32'(ph_av), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcie_s10_tx_fc_tracker.md
# pcie_s10_tx_fc_tracker

Segmented TX flow-control credit tracker for the Stratix 10 PCIe hard IP interface, generalised to SEG_COUNT segments and configurable credit-counter widths. Sits between the application TX path and the hard IP credit interface (tx_*_cdts, tx_*_cdts_consumed, tx_cdts_type, tx_cdts_data_value). Grants TLP transmission only when enough posted (P), non-posted (NP) or completion (CPL) header/data credits remain, and accounts for credits reserved by grants but not yet reported consumed. Handles infinite credits and modular counter wrap.

## Interface
- SEG_COUNT, 1: segments per cycle on the credit-consumed interface (1, 2 or 4)
- HDR_WIDTH, 8: header credit counter width
- DATA_WIDTH, 12: data credit counter width (1 credit = 16 bytes)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- tx_ph_cdts / tx_nph_cdts / tx_cplh_cdts  in  HDR_WIDTH  cumulative header credit limit (modulo 2^HDR_WIDTH)
- tx_pd_cdts / tx_npd_cdts / tx_cpld_cdts  in  DATA_WIDTH  cumulative data credit limit (modulo 2^DATA_WIDTH)
- tx_hdr_cdts_consumed  in  SEG_COUNT  per segment: one header credit consumed
- tx_data_cdts_consumed  in  SEG_COUNT  per segment: data credits consumed
- tx_cdts_type  in  SEG_COUNT*2  per segment type: 0 P, 1 NP, 2 CPL, 3 ignored
- tx_cdts_data_value  in  SEG_COUNT  per segment: 0 = 1 data credit, 1 = 2 data credits
- req_valid  in  1  TLP credit request valid
- req_type  in  2  0 P, 1 NP, 2 CPL (3: never granted)
- req_data_cdts  in  DATA_WIDTH  data credits required (0 for no payload); header need is always 1
- req_ready  out  1  grant; request accepted when req_valid && req_ready
- ph_av, nph_av, cplh_av  out  HDR_WIDTH  available header credits
- pd_av, npd_av, cpld_av  out  DATA_WIDTH  available data credits
- infinite  out  6  {cpld, cplh, npd, nph, pd, ph} infinite flags
- underflow_err  out  1  sticky: consumed credits exceeded reservation

## Operation
- Six independent credit channels (PH, PD, NPH, NPD, CPLH, CPLD), each holding: registered limit L, consumed counter C, reserved counter R, infinite flag I.
- L registered from the tx_*_cdts input every cycle (1-cycle input pipeline).
- Infinite: on the first cycle after rst deasserts, each channel whose input limit is 0 sets I; I holds until next rst. Infinite channels always satisfy requests; their *_av output reads all-ones.
- Available A = (L - C - R) mod 2^W; if the MSB of A is set (negative), A is forced to 0.
- Consumed: per cycle, sum over all segments with type t: header += 1 per hdr_consumed bit, data += 1 or 2 per data_consumed bit. C += sum (mod 2^W); R -= sum.
- R underflow (sum > R + granted-this-cycle): R clamps to 0, underflow_err sets and stays set until rst.
- Grant: req_ready = req_valid && type != 3 && (I_h || A_h >= 1) && (I_d || req_data_cdts == 0 || A_d >= req_data_cdts), using the current-cycle registered state.
- On handshake: R_h += 1, R_d += req_data_cdts (infinite channels do not reserve).
- Simultaneous grant and consume on one channel: R_next = R + grant - consumed, one update.

## Timing
- Reset values: C = 0, R = 0, I = 0, L = 0, underflow_err = 0, req_ready = 0, all *_av = 0, infinite = 0.
- Limit input to *_av: 1 cycle. Consumed pulse to *_av/grant effect: 1 cycle.
- req_ready combinational from req_valid/req_type/req_data_cdts and registered state; no request-to-ready loop on registered paths.
- Grant at edge N is reflected in A at cycle N+1; back-to-back grants can never oversubscribe.
- req_valid may drop without handshake; no state is held for ungranted requests.
- Counter wrap: C and L wrap independently; A correct while true outstanding < 2^(W-1).
- rst mid-operation: all state cleared next edge; infinite re-sampled on first post-reset cycle.

## Test plan
- Reset then PH limit 4, PD limit 16: four P requests of 4 data credits each granted on consecutive cycles; fifth held (req_ready = 0); ph_av = 0, pd_av = 0.
- SEG_COUNT=2, both segments report PH consumed with data_value 1 in one cycle after two grants of 2 credits each: R_ph 2 -> 0, R_pd 4 -> 0, C_ph = 2, C_pd = 4.
- CPL limits 0 at reset: infinite[5:4] = 2'b11; 100 CPL requests of 32 data credits all granted; cplh_av/cpld_av stay all-ones.
- Limit wrap: C_ph = 250, PH limit steps 254 -> 2 (mod 256), R = 0: ph_av = 8; 8 grants succeed, 9th blocked.
- Consumed pulse with R = 0 on NP: underflow_err = 1, R stays 0, persists until rst.
- rst asserted with R_pd = 20 outstanding: next cycle all counters 0, req_ready = 0, underflow_err = 0.
